// File: rtl/mem_port_arbiter.sv
// Purpose: shares one single-port synchronous RAM between instruction fetch and load/store, with data priority and a fetch starvation guard.
// Latency: grant and memory strobes are combinational in the request cycle; read data returns exactly 1 cycle after acceptance.
// Backpressure: ready is driven to the loser of arbitration as 0; responses cannot be stalled, and requesters hold requests until ready.
module mem_port_arbiter #(
    parameter int ADDRESS_BITS = 16,
    parameter int DATA_WIDTH   = 32,
    parameter int D_STREAK_MAX = 4,
    localparam int STREAK_W    = $clog2(D_STREAK_MAX + 1)
) (
    input  logic                    clock,
    input  logic                    reset,

    input  logic                    i_req_valid,
    input  logic [ADDRESS_BITS-1:0] i_req_addr,
    output logic                    i_req_ready,
    output logic                    i_rsp_valid,
    output logic [DATA_WIDTH-1:0]   i_rsp_data,

    input  logic                    d_req_valid,
    input  logic                    d_req_wen,
    input  logic [ADDRESS_BITS-1:0] d_req_addr,
    input  logic [DATA_WIDTH-1:0]   d_req_wdata,
    output logic                    d_req_ready,
    output logic                    d_rsp_valid,
    output logic [DATA_WIDTH-1:0]   d_rsp_data,

    output logic                    mem_en,
    output logic                    mem_wen,
    output logic [ADDRESS_BITS-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,

    output logic [STREAK_W-1:0]     d_streak
);

    localparam logic [STREAK_W-1:0] STREAK_CAP = STREAK_W'(D_STREAK_MAX);
    localparam logic [STREAK_W-1:0] STREAK_ONE = STREAK_W'(1);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2
    } owner_t;

    owner_t owner;
    logic   grant_i;
    logic   grant_d;

    // Reset gates the grants directly so nothing reaches the RAM while held in reset.
    always_comb begin
        grant_d = reset && d_req_valid && (!i_req_valid || (d_streak < STREAK_CAP));
        grant_i = reset && i_req_valid && !grant_d;
    end

    always_comb begin
        i_req_ready = grant_i;
        d_req_ready = grant_d;
        mem_en      = grant_i | grant_d;
        mem_wen     = grant_d & d_req_wen;
        mem_addr    = grant_d ? d_req_addr : i_req_addr;
        mem_wdata   = d_req_wdata;
    end

    // The streak only counts data grants that overtook a waiting fetch.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            d_streak <= '0;
        end else if (grant_d && i_req_valid) begin
            if (d_streak != STREAK_CAP) begin
                d_streak <= d_streak + STREAK_ONE;
            end
        end else if (grant_i || !i_req_valid) begin
            d_streak <= '0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            owner <= OWN_NONE;
        end else if (grant_i) begin
            owner <= OWN_I;
        end else if (grant_d && !d_req_wen) begin
            owner <= OWN_D;
        end else begin
            owner <= OWN_NONE;
        end
    end

    always_comb begin
        i_rsp_valid = reset && (owner == OWN_I);
        d_rsp_valid = reset && (owner == OWN_D);
        i_rsp_data  = mem_rdata;
        d_rsp_data  = mem_rdata;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed bench for mem_port_arbiter with a RAM model and scoreboarded responses.
module tb_mem_port_arbiter;

    localparam int AW   = 16;
    localparam int DW   = 32;
    localparam int DMAX = 4;
    localparam int SW   = $clog2(DMAX + 1);

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          i_req_valid = 1'b0;
    logic [AW-1:0] i_req_addr = '0;
    logic          i_req_ready;
    logic          i_rsp_valid;
    logic [DW-1:0] i_rsp_data;
    logic          d_req_valid = 1'b0;
    logic          d_req_wen = 1'b0;
    logic [AW-1:0] d_req_addr = '0;
    logic [DW-1:0] d_req_wdata = '0;
    logic          d_req_ready;
    logic          d_rsp_valid;
    logic [DW-1:0] d_rsp_data;
    logic          mem_en;
    logic          mem_wen;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic [SW-1:0] d_streak;

    mem_port_arbiter #(
        .ADDRESS_BITS(AW),
        .DATA_WIDTH  (DW),
        .D_STREAK_MAX(DMAX)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .i_req_valid(i_req_valid),
        .i_req_addr (i_req_addr),
        .i_req_ready(i_req_ready),
        .i_rsp_valid(i_rsp_valid),
        .i_rsp_data (i_rsp_data),
        .d_req_valid(d_req_valid),
        .d_req_wen  (d_req_wen),
        .d_req_addr (d_req_addr),
        .d_req_wdata(d_req_wdata),
        .d_req_ready(d_req_ready),
        .d_rsp_valid(d_rsp_valid),
        .d_rsp_data (d_rsp_data),
        .mem_en     (mem_en),
        .mem_wen    (mem_wen),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .d_streak   (d_streak)
    );

    always #5 clock = ~clock;

    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        return {a ^ 16'hA5C3, ~a};
    endfunction

    // Single-port RAM with 1-cycle read latency, preloaded on the first edge.
    logic [DW-1:0] ram [0:65535];
    logic          ram_ready = 1'b0;
    always @(posedge clock) begin
        if (!ram_ready) begin
            for (int k = 0; k < 65536; k++) ram[k] <= init_val(AW'(k));
            ram_ready <= 1'b1;
        end else if (mem_en && mem_wen) begin
            ram[mem_addr] <= mem_wdata;
        end else if (mem_en) begin
            mem_rdata <= ram[mem_addr];
        end
    end

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    exp_t          i_q[$];
    exp_t          d_q[$];
    logic [DW-1:0] ref_mem [int];
    int            checks = 0;
    int            errors = 0;
    int            model_streak = 0;
    int            i_wait = 0;
    logic          exp_gi = 1'b0;
    logic          exp_gd = 1'b0;
    logic          last_d_rdy = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a);
        if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
        return init_val(a);
    endfunction

    // Monitor: every response must match the oldest outstanding read, due exactly one cycle after acceptance.
    always @(negedge clock) begin
        if (i_rsp_valid) begin
            if (i_q.size() == 0 || i_q[0].due != cyc) begin
                checks++; errors++;
                $display("FAIL i_rsp_unexpected: got valid=1 expected no fetch response (cycle %0d)", cyc);
            end else begin
                chk("i_rsp_data", i_rsp_data, i_q[0].data);
                void'(i_q.pop_front());
            end
        end else if (i_q.size() != 0 && i_q[0].due == cyc) begin
            checks++; errors++;
            $display("FAIL i_rsp_missing: got valid=0 expected data %0h (cycle %0d)", i_q[0].data, cyc);
            void'(i_q.pop_front());
        end
        if (d_rsp_valid) begin
            if (d_q.size() == 0 || d_q[0].due != cyc) begin
                checks++; errors++;
                $display("FAIL d_rsp_unexpected: got valid=1 expected no load response (cycle %0d)", cyc);
            end else begin
                chk("d_rsp_data", d_rsp_data, d_q[0].data);
                void'(d_q.pop_front());
            end
        end else if (d_q.size() != 0 && d_q[0].due == cyc) begin
            checks++; errors++;
            $display("FAIL d_rsp_missing: got valid=0 expected data %0h (cycle %0d)", d_q[0].data, cyc);
            void'(d_q.pop_front());
        end
    end

    // Drive one cycle of requests (called at posedge+1), check combinational outputs at negedge.
    task automatic step(input logic iv, input logic [AW-1:0] ia,
                        input logic dv, input logic dw, input logic [AW-1:0] da,
                        input logic [DW-1:0] dd);
        exp_t e;
        i_req_valid = iv;
        i_req_addr  = ia;
        d_req_valid = dv;
        d_req_wen   = dw;
        d_req_addr  = da;
        d_req_wdata = dd;
        @(negedge clock);
        if (!reset) begin
            exp_gd = 1'b0;
            exp_gi = 1'b0;
            model_streak = 0;
            i_wait = 0;
            i_q.delete();
            d_q.delete();
        end else begin
            // Data wins unless a fetch has already been overtaken DMAX times in a row.
            exp_gd = dv && (!iv || model_streak < DMAX);
            exp_gi = iv && !exp_gd;
        end
        last_d_rdy = d_req_ready;
        chk("i_req_ready", i_req_ready, exp_gi);
        chk("d_req_ready", d_req_ready, exp_gd);
        chk("mem_en", mem_en, exp_gi | exp_gd);
        chk("mem_wen", mem_wen, exp_gd & dw);
        chk("d_streak", d_streak, model_streak);
        if (exp_gd) chk("mem_addr_d", mem_addr, da);
        else if (exp_gi) chk("mem_addr_i", mem_addr, ia);
        if (exp_gd && dw) chk("mem_wdata", mem_wdata, dd);
        if (!reset) begin
            chk("i_rsp_valid_in_reset", i_rsp_valid, 0);
            chk("d_rsp_valid_in_reset", d_rsp_valid, 0);
        end
        if (reset && iv) begin
            if (i_req_ready) begin
                chk("fetch_wait_bound", (i_wait <= DMAX) ? 1 : 0, 1);
                i_wait = 0;
            end else begin
                i_wait++;
            end
        end
        if (exp_gi) begin
            e.data = ref_read(ia); e.due = cyc + 1; i_q.push_back(e);
        end
        if (exp_gd && !dw) begin
            e.data = ref_read(da); e.due = cyc + 1; d_q.push_back(e);
        end
        if (exp_gd && dw) ref_mem[int'(da)] = dd;
        if (reset) begin
            if (exp_gd && iv) model_streak = (model_streak >= DMAX) ? DMAX : model_streak + 1;
            else model_streak = 0;
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic          ip, dp, dw;
        logic [AW-1:0] ia, da;
        logic [DW-1:0] dwd;
        logic [9:0]    pat;

        // Reset held with both requesters active: nothing may be granted.
        step(1'b1, 16'h0000, 1'b1, 1'b0, 16'h0100, '0);
        step(1'b1, 16'h0000, 1'b1, 1'b0, 16'h0100, '0);
        reset = 1'b1;

        // Back-to-back fetches from a preloaded RAM.
        step(1'b1, 16'h0000, 1'b0, 1'b0, '0, '0);
        step(1'b1, 16'h0004, 1'b0, 1'b0, '0, '0);
        step(1'b1, 16'h0008, 1'b0, 1'b0, '0, '0);

        // Data priority over a concurrent fetch.
        step(1'b1, 16'h0010, 1'b1, 1'b0, 16'h0100, '0);
        step(1'b1, 16'h0010, 1'b0, 1'b0, '0, '0);
        step(1'b0, '0, 1'b0, 1'b0, '0, '0);

        // Starvation guard: both sides requesting continuously.
        ia = 16'h0040;
        da = 16'h0300;
        pat = '0;
        for (int k = 0; k < 10; k++) begin
            step(1'b1, ia, 1'b1, 1'b0, da, '0);
            pat[9-k] = last_d_rdy;
            if (exp_gi) ia = ia + 16'd4;
            if (exp_gd) da = da + 16'd4;
        end
        chk("grant_pattern", pat, 10'b1111011110);
        step(1'b0, '0, 1'b0, 1'b0, '0, '0);

        // Write then read the same word.
        step(1'b0, '0, 1'b1, 1'b1, 16'h0200, 32'hDEADBEEF);
        step(1'b0, '0, 1'b1, 1'b0, 16'h0200, '0);
        step(1'b0, '0, 1'b0, 1'b0, '0, '0);

        // Reset lands while a fetch read is in flight: its response must vanish.
        step(1'b1, 16'h0020, 1'b0, 1'b0, '0, '0);
        reset = 1'b0;
        i_q.delete();
        d_q.delete();
        step(1'b0, '0, 1'b0, 1'b0, '0, '0);
        step(1'b1, 16'h0024, 1'b1, 1'b0, 16'h0104, '0);
        reset = 1'b1;
        step(1'b0, '0, 1'b0, 1'b0, '0, '0);
        step(1'b0, '0, 1'b0, 1'b0, '0, '0);

        // Randomized traffic; requests are held until accepted.
        ip = 1'b0; dp = 1'b0; dw = 1'b0; ia = '0; da = '0; dwd = '0;
        for (int n = 0; n < 3000; n++) begin
            if (!ip) begin
                ip = ($urandom_range(0, 3) != 0);
                ia = AW'($urandom_range(16'h60, 16'h8F) * 4);
            end
            if (!dp) begin
                dp  = ($urandom_range(0, 2) != 0);
                dw  = 1'($urandom_range(0, 1));
                da  = AW'(16'h0200 + $urandom_range(0, 15) * 4);
                dwd = $urandom;
            end
            step(ip, ia, dp, dw, da, dwd);
            if (exp_gi) ip = 1'b0;
            if (exp_gd) dp = 1'b0;
        end

        step(1'b0, '0, 1'b0, 1'b0, '0, '0);
        step(1'b0, '0, 1'b0, 1'b0, '0, '0);
        chk("i_q_drained", i_q.size(), 0);
        chk("d_q_drained", d_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one single-ported synchronous RAM between the instruction-fetch requester and the load/store requester of the core. Arbitrates each cycle with data-side priority and a bounded starvation guard for fetch. Drives the memory port and routes the 1-cycle-latency read data back to the requester that issued the read. Sits between fetch/LSU and a single-port variant of main memory, so the dual-port RAM can be replaced.

Parameters:
ADDRESS_BITS, 16, width of all addresses
DATA_WIDTH, 32, width of read/write data
D_STREAK_MAX, 4, max consecutive data grants while a fetch waits (>=1)

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
i_req_valid  in  1  fetch read request
i_req_addr  in  ADDRESS_BITS  fetch address
i_req_ready  out  1  fetch request accepted this cycle
i_rsp_valid  out  1  fetch read data valid
i_rsp_data  out  DATA_WIDTH  fetch read data
d_req_valid  in  1  data request
d_req_wen  in  1  1=write, 0=read
d_req_addr  in  ADDRESS_BITS  data address
d_req_wdata  in  DATA_WIDTH  write data
d_req_ready  out  1  data request accepted this cycle
d_rsp_valid  out  1  load data valid (reads only)
d_rsp_data  out  DATA_WIDTH  load data
mem_en  out  1  memory access this cycle
mem_wen  out  1  memory write strobe
mem_addr  out  ADDRESS_BITS  memory address
mem_wdata  out  DATA_WIDTH  memory write data
mem_rdata  in  DATA_WIDTH  read data, valid the cycle after a read is issued
d_streak  out  $clog2(D_STREAK_MAX+1)  current data-streak count (debug)

Behaviour:
- Handshake: request transfers when valid && ready in the same cycle. The requester holds valid, addr, wen and wdata stable until ready. ready is combinational from both valids and d_streak.
- Grant (combinational, one per cycle):
  - grant_d = d_req_valid && (!i_req_valid || d_streak < D_STREAK_MAX).
  - grant_i = i_req_valid && !grant_d.
  - i_req_ready = grant_i. d_req_ready = grant_d.
- Memory port:
  - mem_en = grant_i | grant_d.
  - mem_wen = grant_d & d_req_wen.
  - mem_addr = grant_d ? d_req_addr : i_req_addr.
  - mem_wdata = d_req_wdata.
  - When mem_en=0: mem_addr and mem_wdata are don't-care; mem_wen is 0.
- Streak counter:
  - On a grant_d cycle with i_req_valid=1: increment, saturating at D_STREAK_MAX.
  - On a grant_i cycle, or any cycle with i_req_valid=0: clear to 0.
  - Otherwise: hold.
- Response tag, registered: owner <= READ_I if a fetch is granted, READ_D if a data read is granted, else NONE (includes writes and idle cycles).
  - i_rsp_valid = (owner==READ_I). d_rsp_valid = (owner==READ_D).
  - Both rsp_data outputs = mem_rdata, unregistered pass-through.
  - Read latency is exactly 1 cycle after acceptance. There is no response back-pressure.
- Throughput: one access per cycle, no bubbles between back-to-back grants of either or mixed type.
- Writes produce no response; the write completes on the accept edge.
- Reset (reset=0, asynchronous):
  - owner=NONE, d_streak=0.
  - While reset=0: i_req_ready, d_req_ready, mem_en, mem_wen, i_rsp_valid and d_rsp_valid are all forced 0.
  - A read in flight when reset asserts is dropped; no response is produced after reset deasserts.
- Boundary cases:
  - Both valid with d_streak==D_STREAK_MAX: fetch wins, streak clears.
  - Fetch is therefore guaranteed a grant within D_STREAK_MAX+1 cycles of asserting valid.
  - A data requester is never starved: at most one fetch is forced between data streaks.

Test Plan:
- Reset: hold reset=0 with both valids high -> all readys, mem_en and rsp_valids 0; d_streak=0. Release -> grants begin the same cycle.
- Fetch only: i_req_valid=1, addrs 0x0000, 0x0004, 0x0008 on consecutive cycles, RAM preloaded -> i_req_ready=1 every cycle; i_rsp_valid=1 with matching data one cycle after each; no gaps.
- Priority: both valid, d_req read 0x0100 -> d granted, mem_addr=0x0100, i_req_ready=0; d_rsp_valid next cycle; d_streak=1.
- Starvation guard with D_STREAK_MAX=4: both valid continuously -> grant pattern D,D,D,D,I,D,D,D,D,I; d_streak sequence 1,2,3,4,0.
- Write then read: d write 0x0200<=0xDEADBEEF, then d read 0x0200 -> mem_wen=1 for one cycle, no d_rsp_valid for the write; read returns 0xDEADBEEF one cycle later.
- Reset mid-read: fetch accepted, then reset asserted before the next edge -> i_rsp_valid stays 0 through and after reset release.
